result_write_arbiter: RTL and testbench

- Shares the single frame-buffer write port (oX/oY/pixel/wren) between NUM_REQ parallel box-filter result streams.
- Grants are round-robin with a valid/ready handshake, so simultaneous results are never dropped; losers stall instead.
- Counts committed pixels and reports frame completion to the top-level controller.
- Sits between the box_filter instances and the display write interface.

---
 rtl/result_write_arbiter_pkg.sv | 21 ++
 rtl/result_write_arbiter_rr_priority_picker.sv | 29 ++
 rtl/result_write_arbiter.sv | 144 ++++++++++++++
 tb/tb_result_write_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_write_arbiter_pkg.sv
// Shared constants and state encoding for the frame-buffer result write arbiter.
package result_write_arbiter_pkg;

    localparam int unsigned NUM_REQ_BITS = 2;
    localparam int unsigned NUM_REQ      = 1 << NUM_REQ_BITS;
    localparam int unsigned WIDTH_BITS   = 8;
    localparam int unsigned HEIGHT_BITS  = 8;
    localparam int unsigned TOTAL_PIXELS = 1 << (WIDTH_BITS + HEIGHT_BITS);

    localparam int unsigned COUNT_BITS = WIDTH_BITS + HEIGHT_BITS + 1;
    localparam int unsigned STALL_BITS = 16;

    // Packed request bus widths; requester k occupies slice [k*W +: W].
    localparam int unsigned COL_BUS_W = NUM_REQ * WIDTH_BITS;
    localparam int unsigned ROW_BUS_W = NUM_REQ * HEIGHT_BITS;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/result_write_arbiter_rr_priority_picker.sv
// Round-robin priority search: first valid requester at or after the pointer, modulo NUM_REQ.
module result_write_arbiter_rr_priority_picker
    import result_write_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0]      valid_i,
    input  logic [NUM_REQ_BITS-1:0] ptr_i,
    output logic [NUM_REQ_BITS-1:0] grant_o,
    output logic                    any_valid_o
);

    logic [NUM_REQ_BITS-1:0] idx;
    logic                    found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // Index arithmetic wraps naturally because NUM_REQ is a power of two.
            idx = ptr_i + NUM_REQ_BITS'(i);
            if (!found && valid_i[idx]) begin
                grant_o = idx;
                found   = 1'b1;
            end
        end
        any_valid_o = found;
    end

endmodule

// File: rtl/result_write_arbiter.sv
// Round-robin arbiter sharing the frame-buffer write port between box-filter result streams.
module result_write_arbiter
    import result_write_arbiter_pkg::*;
(
    input  logic                    clock,
    input  logic                    not_reset,
    input  logic                    start,
    input  logic [NUM_REQ-1:0]      iReqValid,
    input  logic [COL_BUS_W-1:0]    iReqCol,
    input  logic [ROW_BUS_W-1:0]    iReqRow,
    input  logic [NUM_REQ-1:0]      iReqData,
    output logic [NUM_REQ-1:0]      oReqReady,
    output logic [HEIGHT_BITS-1:0]  oX,
    output logic [WIDTH_BITS-1:0]   oY,
    output logic                    oData,
    output logic                    oWren,
    output logic [NUM_REQ_BITS-1:0] oGrantIdx,
    output logic [COUNT_BITS-1:0]   oWriteCount,
    output logic                    oAllWritten,
    output logic [STALL_BITS-1:0]   oStallCycles
);

    logic [1:0]              state_q, state_d;
    logic [NUM_REQ_BITS-1:0] ptr_q, ptr_d;
    logic                    wren_q, wren_d;
    logic [HEIGHT_BITS-1:0]  x_q, x_d;
    logic [WIDTH_BITS-1:0]   y_q, y_d;
    logic                    data_q, data_d;
    logic [NUM_REQ_BITS-1:0] grant_idx_q, grant_idx_d;
    logic [COUNT_BITS-1:0]   count_q, count_d;
    logic [STALL_BITS-1:0]   stall_q, stall_d;

    logic [NUM_REQ_BITS-1:0] grant;
    logic                    any_valid;
    logic                    run;
    logic                    transfer;
    logic                    stall;
    logic [NUM_REQ_BITS:0]   num_valid;
    logic [HEIGHT_BITS-1:0]  row_sel;
    logic [WIDTH_BITS-1:0]   col_sel;

    result_write_arbiter_rr_priority_picker u_picker (
        .valid_i     (iReqValid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .any_valid_o (any_valid)
    );

    assign run      = (state_q == StRun);
    // The granted requester is valid by construction, so any valid in RUN is a transfer.
    assign transfer = run && any_valid;
    assign row_sel  = iReqRow[grant*HEIGHT_BITS +: HEIGHT_BITS];
    assign col_sel  = iReqCol[grant*WIDTH_BITS +: WIDTH_BITS];

    always_comb begin
        oReqReady = '0;
        if (transfer) begin
            oReqReady[grant] = 1'b1;
        end
    end

    always_comb begin
        num_valid = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            num_valid = num_valid + (NUM_REQ_BITS + 1)'(iReqValid[k]);
        end
    end

    assign stall = run && (num_valid > (NUM_REQ_BITS + 1)'(transfer));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        wren_d      = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        data_d      = data_q;
        grant_idx_d = grant_idx_q;
        count_d     = count_q;
        stall_d     = stall_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    ptr_d   = '0;
                    count_d = '0;
                    stall_d = '0;
                end
            end
            StRun: begin
                if (stall && (stall_q != '1)) begin
                    stall_d = stall_q + 1'b1;
                end
                if (transfer) begin
                    ptr_d       = grant + 1'b1;
                    wren_d      = 1'b1;
                    x_d         = row_sel;
                    y_d         = col_sel;
                    data_d      = iReqData[grant];
                    grant_idx_d = grant;
                    count_d     = count_q + 1'b1;
                    if (count_q == COUNT_BITS'(TOTAL_PIXELS - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            wren_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            data_q      <= 1'b0;
            grant_idx_q <= '0;
            count_q     <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            wren_q      <= wren_d;
            x_q         <= x_d;
            y_q         <= y_d;
            data_q      <= data_d;
            grant_idx_q <= grant_idx_d;
            count_q     <= count_d;
            stall_q     <= stall_d;
        end
    end

    assign oX           = x_q;
    assign oY           = y_q;
    assign oData        = data_q;
    assign oWren        = wren_q;
    assign oGrantIdx    = grant_idx_q;
    assign oWriteCount  = count_q;
    assign oAllWritten  = (state_q == StDone);
    assign oStallCycles = stall_q;

endmodule

// File: tb/tb_result_write_arbiter.sv
// Randomized scoreboard bench for result_write_arbiter against a frame-level reference model.
module tb_result_write_arbiter;

    localparam int NR    = 4;
    localparam int TOTAL = 65536;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic        clock;
    logic        not_reset;
    logic        start;
    logic [3:0]  iReqValid;
    logic [31:0] iReqCol;
    logic [31:0] iReqRow;
    logic [3:0]  iReqData;
    logic [3:0]  oReqReady;
    logic [7:0]  oX;
    logic [7:0]  oY;
    logic        oData;
    logic        oWren;
    logic [1:0]  oGrantIdx;
    logic [16:0] oWriteCount;
    logic        oAllWritten;
    logic [15:0] oStallCycles;

    result_write_arbiter dut (
        .clock        (clock),
        .not_reset    (not_reset),
        .start        (start),
        .iReqValid    (iReqValid),
        .iReqCol      (iReqCol),
        .iReqRow      (iReqRow),
        .iReqData     (iReqData),
        .oReqReady    (oReqReady),
        .oX           (oX),
        .oY           (oY),
        .oData        (oData),
        .oWren        (oWren),
        .oGrantIdx    (oGrantIdx),
        .oWriteCount  (oWriteCount),
        .oAllWritten  (oAllWritten),
        .oStallCycles (oStallCycles)
    );

    typedef struct {
        logic [7:0] row;
        logic [7:0] col;
        logic       data;
        int         idx;
        int         cnt;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] row_a[NR];
    logic [7:0] col_a[NR];
    logic       data_a[NR];

    // Reference model state: frame phase, rotating priority start, committed pixels, stalls.
    int m_state = M_IDLE;
    int m_ptr = 0;
    int m_count = 0;
    int m_stall = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic pack();
        for (int k = 0; k < NR; k++) begin
            iReqRow[k*8 +: 8] = row_a[k];
            iReqCol[k*8 +: 8] = col_a[k];
            iReqData[k]       = data_a[k];
        end
    endtask

    // Requesters hold valid+payload until accepted; idle/accepted ones re-raise with rate %.
    task automatic run_cycles(input int n, input int rate);
        logic [3:0] acc;
        repeat (n) begin
            @(negedge clock);
            acc = oReqReady & iReqValid;
            @(posedge clock);
            #1;
            for (int k = 0; k < NR; k++) begin
                if (acc[k] || !iReqValid[k]) begin
                    if (int'($urandom_range(99)) < rate) begin
                        iReqValid[k] = 1'b1;
                        row_a[k]     = 8'($urandom_range(255));
                        col_a[k]     = 8'($urandom_range(255));
                        data_a[k]    = 1'($urandom_range(1));
                    end else begin
                        iReqValid[k] = 1'b0;
                    end
                end
            end
            pack();
        end
    endtask

    // Reference model: evaluates each cycle's inputs just before the active edge.
    int m_g;
    int m_nv;
    int m_k;
    logic [3:0] m_ready;
    exp_t m_e;
    always @(negedge clock) begin
        if (!not_reset) begin
            m_state = M_IDLE;
            m_ptr   = 0;
            m_count = 0;
            m_stall = 0;
            exp_q.delete();
        end else begin
            m_g     = -1;
            m_ready = 4'b0000;
            if (m_state == M_RUN) begin
                for (int i = 0; i < NR; i++) begin
                    m_k = (m_ptr + i) % NR;
                    if (m_g < 0 && iReqValid[m_k]) m_g = m_k;
                end
            end
            if (m_g >= 0) m_ready[m_g] = 1'b1;
            check("ready", 32'(oReqReady), 32'(m_ready));
            check("write_count", 32'(oWriteCount), 32'(m_count));
            check("stall_cycles", 32'(oStallCycles), 32'(m_stall));
            check("all_written", 32'(oAllWritten), 32'(m_state == M_DONE));
            m_nv = $countones(iReqValid);
            if (m_state == M_RUN) begin
                if (m_nv > ((m_g >= 0) ? 1 : 0)) m_stall = (m_stall == 65535) ? 65535 : m_stall + 1;
                if (m_g >= 0) begin
                    m_count  = m_count + 1;
                    m_e.row  = row_a[m_g];
                    m_e.col  = col_a[m_g];
                    m_e.data = data_a[m_g];
                    m_e.idx  = m_g;
                    m_e.cnt  = m_count;
                    m_e.cyc  = cyc;
                    exp_q.push_back(m_e);
                    m_ptr = (m_g + 1) % NR;
                    if (m_count == TOTAL) m_state = M_DONE;
                end
            end else if (start) begin
                m_state = M_RUN;
                m_ptr   = 0;
                m_count = 0;
                m_stall = 0;
            end
        end
    end

    // Monitor: every write strobe must match the oldest outstanding expected write.
    exp_t mon_e;
    always @(negedge clock) begin
        if (not_reset) begin
            if (oWren) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wren", 32'(oWren), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_x_row", 32'(oX), 32'(mon_e.row));
                    check("wr_y_col", 32'(oY), 32'(mon_e.col));
                    check("wr_data", 32'(oData), 32'(mon_e.data));
                    check("wr_grant_idx", 32'(oGrantIdx), 32'(mon_e.idx));
                    check("wr_count", 32'(oWriteCount), 32'(mon_e.cnt));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("missing_wren", 32'(oWren), 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        not_reset = 1'b0;
        start     = 1'b0;
        iReqValid = 4'b0000;
        for (int k = 0; k < NR; k++) begin
            row_a[k]  = '0;
            col_a[k]  = '0;
            data_a[k] = 1'b0;
        end
        pack();
        repeat (3) @(posedge clock);
        #1;
        check("rst_wren", 32'(oWren), 32'd0);
        check("rst_count", 32'(oWriteCount), 32'd0);
        not_reset = 1'b1;

        // Single requester 2 with a known payload.
        row_a[2]  = 8'd5;
        col_a[2]  = 8'd9;
        data_a[2] = 1'b1;
        iReqValid = 4'b0100;
        pack();
        start = 1'b1;
        run_cycles(1, 0);
        start = 1'b0;
        #3;
        check("t1_ready", 32'(oReqReady), 32'h4);
        run_cycles(1, 0);
        check("t1_wren", 32'(oWren), 32'd1);
        check("t1_x", 32'(oX), 32'd5);
        check("t1_y", 32'(oY), 32'd9);
        check("t1_data", 32'(oData), 32'd1);
        check("t1_grant", 32'(oGrantIdx), 32'd2);
        check("t1_count", 32'(oWriteCount), 32'd1);
        run_cycles(2, 0);

        // Saturated traffic up to count 10, then a start pulse that must be ignored.
        guard = 0;
        while (oWriteCount < 17'd10 && guard < 50) begin
            run_cycles(1, 100);
            guard++;
        end
        start = 1'b1;
        run_cycles(1, 100);
        start = 1'b0;
        run_cycles(1, 100);
        check("t6_not_cleared", 32'(oWriteCount > 17'd10), 32'd1);
        run_cycles(20, 100);

        // Mixed random contention.
        run_cycles(300, 60);
        run_cycles(100, 25);

        // Async reset mid-frame with a write pending.
        guard = 0;
        while (oWriteCount < 17'd1000 && guard < 2000) begin
            run_cycles(1, 100);
            guard++;
        end
        check("t5_pending", 32'(oWren), 32'd1);
        #2;
        not_reset = 1'b0;
        #1;
        check("t5_async_wren", 32'(oWren), 32'd0);
        check("t5_async_count", 32'(oWriteCount), 32'd0);
        check("t5_async_ready", 32'(oReqReady), 32'd0);
        repeat (2) @(posedge clock);
        #2;
        not_reset = 1'b1;
        run_cycles(3, 100);
        check("t5_idle_ready", 32'(oReqReady), 32'd0);
        check("t5_idle_count", 32'(oWriteCount), 32'd0);

        // Full frame with all four requesters valid from pointer 0.
        start = 1'b1;
        run_cycles(1, 100);
        start = 1'b0;
        guard = 0;
        while (!oAllWritten && guard < 70000) begin
            run_cycles(1, 100);
            guard++;
        end
        check("t4_all_written", 32'(oAllWritten), 32'd1);
        check("t4_last_wren", 32'(oWren), 32'd1);
        check("t4_count", 32'(oWriteCount), 32'd65536);
        run_cycles(3, 100);
        check("t4_done_ready", 32'(oReqReady), 32'd0);
        check("t4_done_count", 32'(oWriteCount), 32'd65536);
        start = 1'b1;
        run_cycles(1, 100);
        start = 1'b0;
        check("t4_restart_count", 32'(oWriteCount), 32'd0);
        check("t4_restart_flag", 32'(oAllWritten), 32'd0);
        run_cycles(10, 70);
        iReqValid = 4'b0000;
        run_cycles(3, 0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
